// File: rtl/ram_registros_rtc.sv
// ram_registros_rtc: 32x8 RTC register bank written by ROM during init or by bus; tracks init coverage and flags bad addressing.
// Optional per-location even parity with error_paridad when RAM_PARIDAD_EN is defined.
module ram_registros_rtc #(
  parameter int               N_POS       = 32,
  parameter int               ANCHO       = 8,
  parameter logic [ANCHO-1:0] VALOR_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rom_to_ram,
  input  logic [ANCHO-1:0] dato_rom,
  input  logic [ANCHO-1:0] dato_bus,
  input  logic [N_POS-1:0] dir_ram,
  input  logic             w_ram_enable,
  input  logic             r_ram_enable,
  output logic [ANCHO-1:0] dato_ram,
  output logic             dato_valido,
  output logic             inic_completa,
  output logic             error_dir,
  output logic [N_POS-1:0] mapa_escrito,
  output logic             error_paridad
);
  localparam int IW = $clog2(N_POS);
  localparam logic [N_POS-1:0] UNO = 1;
  logic [ANCHO-1:0] mem_q [N_POS];
  logic [ANCHO-1:0] dato_ram_q, dato_ram_d, dato_w;
  logic [N_POS-1:0] mapa_q, mapa_d;
  logic [IW-1:0] idx;
  logic legal, multi, wr, rd, err, ini, inic_q, inic_d, rom_q, valido_q, err_q;
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_POS; i++) if (dir_ram[i]) idx = IW'(i);
  end
  assign legal  = $onehot(dir_ram);
  assign multi  = (|dir_ram) && !legal;
  assign wr     = w_ram_enable && legal;
  assign rd     = r_ram_enable && !w_ram_enable && legal;
  assign err    = (legal && w_ram_enable && r_ram_enable) || (multi && (w_ram_enable || r_ram_enable));
  // A rising edge of rom_to_ram starts a fresh init pass
  assign ini    = rom_to_ram && !rom_q;
  assign dato_w = rom_to_ram ? dato_rom : dato_bus;
  always_comb begin
    mapa_d     = (ini ? '0 : mapa_q) | ((wr && rom_to_ram) ? (UNO << idx) : '0);
    inic_d     = !ini && (inic_q || (&mapa_q));
    dato_ram_d = rd ? mem_q[idx] : dato_ram_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_POS; i++) mem_q[i] <= VALOR_RESET;
      dato_ram_q <= '0;
      mapa_q     <= '0;
      inic_q     <= 1'b0;
      rom_q      <= 1'b0;
      valido_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (wr) mem_q[idx] <= dato_w;
      dato_ram_q <= dato_ram_d;
      mapa_q     <= mapa_d;
      inic_q     <= inic_d;
      rom_q      <= rom_to_ram;
      valido_q   <= rd;
      err_q      <= err;
    end
  end
  assign dato_ram      = dato_ram_q;
  assign dato_valido   = valido_q;
  assign inic_completa = inic_q;
  assign error_dir     = err_q;
  assign mapa_escrito  = mapa_q;
`ifdef RAM_PARIDAD_EN
  logic par_q [N_POS];
  logic err_par_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_POS; i++) par_q[i] <= ^VALOR_RESET;
      err_par_q <= 1'b0;
    end else begin
      if (wr) par_q[idx] <= ^dato_w;
      err_par_q <= rd && ((^mem_q[idx]) != par_q[idx]);
    end
  end
  assign error_paridad = err_par_q;
`else
  assign error_paridad = 1'b0;
`endif
endmodule

// File: tb/tb_ram_registros_rtc.sv
// tb_ram_registros_rtc: scoreboard bench for ram_registros_rtc; read data expectations queued on request, checked on dato_valido.
module tb_ram_registros_rtc;
  logic clk = 0, reset = 1, rom_to_ram = 0, w_ram_enable = 0, r_ram_enable = 0;
  logic [7:0] dato_rom = 0, dato_bus = 0, dato_ram;
  logic [31:0] dir_ram = 0, mapa_escrito;
  logic dato_valido, inic_completa, error_dir, error_paridad;
  logic [7:0] model [32];
  logic [7:0] sb [$];
  logic [7:0] exp_d;
  int tests = 0, fails = 0;

  ram_registros_rtc dut (
    .clk(clk), .reset(reset), .rom_to_ram(rom_to_ram), .dato_rom(dato_rom), .dato_bus(dato_bus),
    .dir_ram(dir_ram), .w_ram_enable(w_ram_enable), .r_ram_enable(r_ram_enable), .dato_ram(dato_ram),
    .dato_valido(dato_valido), .inic_completa(inic_completa), .error_dir(error_dir),
    .mapa_escrito(mapa_escrito), .error_paridad(error_paridad)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_ram_enable = 0;
    r_ram_enable = 0;
    dir_ram = 0;
  endtask

  task automatic wr(input int k, input logic [7:0] d, input logic rom);
    rom_to_ram = rom;
    if (rom) dato_rom = d; else dato_bus = d;
    dir_ram = 32'd1 << k;
    w_ram_enable = 1;
    r_ram_enable = 0;
    tick();
    model[k] = d;
    idle();
  endtask

  task automatic rd(input int k);
    dir_ram = 32'd1 << k;
    r_ram_enable = 1;
    w_ram_enable = 0;
    sb.push_back(model[k]);
    tick();
    idle();
    tests++;
    if (dato_valido !== 1'b1) begin
      fails++;
      $display("FAIL rd_valid loc %0d: got %b want 1", k, dato_valido);
    end else if (sb.size() == 0) begin
      fails++;
      $display("FAIL rd_sb loc %0d: scoreboard empty", k);
    end else begin
      exp_d = sb.pop_front();
      if (dato_ram !== exp_d) begin
        fails++;
        $display("FAIL rd_data loc %0d: got %h want %h", k, dato_ram, exp_d);
      end
    end
    tests++;
    if (error_dir !== 1'b0 || error_paridad !== 1'b0) begin
      fails++;
      $display("FAIL rd_err loc %0d: got err_dir=%b err_par=%b want 0 0", k, error_dir, error_paridad);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    tests++;
    if ({dato_ram, dato_valido, inic_completa, error_dir, mapa_escrito} !== '0) begin
      fails++;
      $display("FAIL reset_outs: got ram=%h v=%b ic=%b ed=%b map=%h want all 0",
               dato_ram, dato_valido, inic_completa, error_dir, mapa_escrito);
    end
    reset = 0;
    for (int k = 0; k < 32; k++) model[k] = 8'h00;
    for (int k = 0; k < 32; k++) rd(k);
    tick();
    tests++;
    if (dato_valido !== 1'b0 || inic_completa !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got v=%b ic=%b want 0 0", dato_valido, inic_completa);
    end
  endtask

  task automatic test_init();
    for (int k = 0; k < 32; k++) begin
      wr(k, 8'(k + 8'h10), 1'b1);
      if (k == 0) begin
        tests++;
        if (mapa_escrito !== 32'h1) begin
          fails++;
          $display("FAIL init_first_bit: got %h want 00000001", mapa_escrito);
        end
      end
    end
    tests++;
    if (mapa_escrito !== 32'hFFFF_FFFF || inic_completa !== 1'b0) begin
      fails++;
      $display("FAIL init_map_full: got map=%h ic=%b want ffffffff 0", mapa_escrito, inic_completa);
    end
    dir_ram = 0;
    w_ram_enable = 1;
    tick();
    idle();
    tests++;
    if (error_dir !== 1'b0 || inic_completa !== 1'b1 || dato_valido !== 1'b0) begin
      fails++;
      $display("FAIL init_zero_cycle: got ed=%b ic=%b v=%b want 0 1 0", error_dir, inic_completa, dato_valido);
    end
    rd(5);
  endtask

  task automatic test_bus_write();
    wr(10, 8'h3A, 1'b0);
    rd(10);
    tests++;
    if (inic_completa !== 1'b1 || mapa_escrito !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL bus_keeps_init: got ic=%b map=%h want 1 ffffffff", inic_completa, mapa_escrito);
    end
  endtask

  task automatic test_illegal();
    dato_bus = 8'hFF;
    dir_ram = 32'h3;
    w_ram_enable = 1;
    tick();
    idle();
    tests++;
    if (error_dir !== 1'b1 || dato_valido !== 1'b0) begin
      fails++;
      $display("FAIL illegal_wr_err: got ed=%b v=%b want 1 0", error_dir, dato_valido);
    end
    tick();
    tests++;
    if (error_dir !== 1'b0) begin
      fails++;
      $display("FAIL illegal_pulse: got %b want 0", error_dir);
    end
    rd(0);
    rd(1);
    dir_ram = 32'h8000_0100;
    r_ram_enable = 1;
    tick();
    idle();
    tests++;
    if (error_dir !== 1'b1 || dato_valido !== 1'b0) begin
      fails++;
      $display("FAIL illegal_rd_err: got ed=%b v=%b want 1 0", error_dir, dato_valido);
    end
    r_ram_enable = 1;
    tick();
    idle();
    tests++;
    if (error_dir !== 1'b0 || dato_valido !== 1'b0) begin
      fails++;
      $display("FAIL zero_addr_rd: got ed=%b v=%b want 0 0", error_dir, dato_valido);
    end
  endtask

  task automatic test_conflict();
    dato_bus = 8'h5C;
    dir_ram = 32'h4;
    w_ram_enable = 1;
    r_ram_enable = 1;
    tick();
    idle();
    model[2] = 8'h5C;
    tests++;
    if (error_dir !== 1'b1 || dato_valido !== 1'b0) begin
      fails++;
      $display("FAIL conflict: got ed=%b v=%b want 1 0", error_dir, dato_valido);
    end
    rd(2);
  endtask

  task automatic test_reset_mid_init();
    rom_to_ram = 0;
    tick();
    for (int k = 0; k < 10; k++) wr(k, 8'(k + 8'hA0), 1'b1);
    rom_to_ram = 0;
    reset = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 32; k++) model[k] = 8'h00;
    tests++;
    if (mapa_escrito !== 32'h0 || inic_completa !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got map=%h ic=%b want 0 0", mapa_escrito, inic_completa);
    end
    rd(4);
    rd(20);
    for (int k = 31; k > 0; k--) wr(k, 8'(8'hC0 ^ k), 1'b1);
    tick();
    tick();
    tests++;
    if (inic_completa !== 1'b0 || mapa_escrito !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL restart_partial: got ic=%b map=%h want 0 fffffffe", inic_completa, mapa_escrito);
    end
    wr(0, 8'h42, 1'b1);
    tick();
    tests++;
    if (inic_completa !== 1'b1) begin
      fails++;
      $display("FAIL restart_done: got ic=%b want 1", inic_completa);
    end
    wr(0, 8'h77, 1'b1);
    tests++;
    if (mapa_escrito !== 32'hFFFF_FFFF || inic_completa !== 1'b1) begin
      fails++;
      $display("FAIL rewrite_rom: got map=%h ic=%b want ffffffff 1", mapa_escrito, inic_completa);
    end
    rd(0);
    rd(7);
    rom_to_ram = 0;
  endtask

  task automatic test_parity();
`ifdef RAM_PARIDAD_EN
    wr(7, 8'h81, 1'b0);
    dut.par_q[7] = ~dut.par_q[7];
    dir_ram = 32'h80;
    r_ram_enable = 1;
    tick();
    idle();
    tests++;
    if (dato_valido !== 1'b1 || error_paridad !== 1'b1 || dato_ram !== 8'h81) begin
      fails++;
      $display("FAIL parity_err: got v=%b ep=%b d=%h want 1 1 81", dato_valido, error_paridad, dato_ram);
    end
    tick();
    tests++;
    if (error_paridad !== 1'b0) begin
      fails++;
      $display("FAIL parity_pulse: got %b want 0", error_paridad);
    end
`else
    tick();
    tests++;
    if (error_paridad !== 1'b0) begin
      fails++;
      $display("FAIL parity_tied: got %b want 0", error_paridad);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_bus_write();
    test_illegal();
    test_conflict();
    test_reset_mid_init();
    test_parity();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
